pkt_dispatch_mc: RTL and testbench

//  Parametrised multi-PE packet dispatcher between the packet ingress and the per-PE dmaWR data/length FIFOs.

---
 rtl/pkt_dispatch_mc_pkg.sv | 40 ++++
 rtl/pkt_dispatch_mc_rr.sv | 44 ++++
 rtl/pkt_dispatch_mc.sv | 144 ++++++++++++++
 tb/tb_pkt_dispatch_mc.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_dispatch_mc_pkg.sv
// Shared constants, word layout and length helpers for the multi-PE packet dispatcher.
package pkt_dispatch_pkg;

   localparam logic [1:0] HEAD = 2'b11;
   localparam logic [1:0] TAIL = 2'b10;
   localparam logic [1:0] BODY = 2'b01;

   localparam int unsigned DMAC_LSB   = 120;
   localparam int unsigned SMAC_LSB   = 112;
   localparam int unsigned TYPE_LSB   = 104;
   localparam int unsigned VBYTES_LSB = 128;

   localparam int unsigned PKT_W = 134;
   localparam int unsigned LEN_W = 16;
   localparam int unsigned CNT_W = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BODY = 1'b1
   } state_e;

   typedef struct packed {
      logic [1:0]   flag;
      logic [3:0]   vbytes;
      logic [127:0] data;
   } pkt_word_t;

   // Saturating length accumulate; a packet longer than 64 KiB reports 16'hFFFF.
   function automatic logic [LEN_W-1:0] len_add(input logic [LEN_W-1:0] len, input logic [4:0] inc);
      logic [LEN_W:0] sum;
      sum = {1'b0, len} + (LEN_W+1)'(inc);
      return sum[LEN_W] ? '1 : sum[LEN_W-1:0];
   endfunction

   // Tail valid-byte nibble: 0 encodes a full 16-byte word.
   function automatic logic [4:0] tail_bytes(input logic [3:0] nib);
      return (nib == 4'd0) ? 5'd16 : {1'b0, nib};
   endfunction

endpackage

// File: rtl/pkt_dispatch_mc_rr.sv
// Round-robin fallback picker: first requester at or after the pointer; pointer moves past the winner on advance.
module dispatch_rr_pick
   import pkt_dispatch_pkg::*;
#(
   parameter  int unsigned NUM_PE = 3,
   localparam int unsigned PTR_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
)
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NUM_PE-1:0] req_i,
   input  logic              adv_i,
   output logic [NUM_PE-1:0] grant_o
);

   logic [PTR_W-1:0]  ptr_q, ptr_d, next_ptr_c;
   logic [NUM_PE-1:0] rot_c;
   int unsigned       idx;

   always_comb begin
      grant_o    = '0;
      next_ptr_c = ptr_q;
      rot_c      = '0;
      idx        = 0;
      for (int unsigned k = 0; k < NUM_PE; k++) begin
         if (grant_o == '0) begin
            idx   = (32'(ptr_q) + k) % NUM_PE;
            rot_c = req_i >> idx;
            if (rot_c[0]) begin
               grant_o    = NUM_PE'(1) << idx;
               next_ptr_c = PTR_W'((idx + 1) % NUM_PE);
            end
         end
      end
   end

   assign ptr_d = adv_i ? next_ptr_c : ptr_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/pkt_dispatch_mc.sv
// Multi-PE packet dispatcher: steers each packet to a per-PE bitmap (header bits, byte filters, RR fallback),
// tracks the byte length and counts dropped and truncated packets.
module pkt_dispatch_mc
   import pkt_dispatch_pkg::*;
#(
   parameter int unsigned NUM_PE       = 3,
   parameter int unsigned USEDW_W      = 10,
   parameter int unsigned READY_THRESH = 28,
   parameter int unsigned BMAP_LSB     = 80,
   parameter int unsigned RR_FALLBACK  = 1
)
(
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_pkt_valid,
   input  logic [PKT_W-1:0]          i_pkt,
   output logic [NUM_PE-1:0]         o_pkt_valid,
   output logic [PKT_W-1:0]          o_pkt,
   input  logic [NUM_PE*USEDW_W-1:0] i_usedw_dmaWR,
   output logic [LEN_W-1:0]          o_din_length,
   output logic [NUM_PE-1:0]         o_wren_length,
   input  logic [NUM_PE-1:0]         i_filter_en,
   input  logic [NUM_PE-1:0]         i_filter_dmac_en,
   input  logic [NUM_PE-1:0]         i_filter_smac_en,
   input  logic [NUM_PE-1:0]         i_filter_type_en,
   input  logic [NUM_PE*8-1:0]       i_filter_dmac,
   input  logic [NUM_PE*8-1:0]       i_filter_smac,
   input  logic [NUM_PE*8-1:0]       i_filter_type,
   input  logic [NUM_PE-1:0]         i_start_en,
   input  logic                      i_rr_en,
   output logic [CNT_W-1:0]          o_drop_cnt,
   output logic [CNT_W-1:0]          o_err_cnt,
   output logic                      d_state_1b
);

   state_e            state_q, state_d;
   logic [NUM_PE-1:0] bmap_q, bmap_d, valid_q, valid_d, wren_q, wren_d;
   logic [LEN_W-1:0]  len_q, len_d, din_len_q, din_len_d;
   logic [CNT_W-1:0]  drop_q, drop_d, err_q, err_d;
   logic [PKT_W-1:0]  pkt_q;

   pkt_word_t         word_c;
   logic [NUM_PE-1:0] ready_c, hit_c, claim_c, elig_c, rr_grant_c, head_bmap_c;
   logic              is_head_c, is_body_c, is_tail_c, fallback_c, rr_adv_c;

   assign word_c    = pkt_word_t'(i_pkt);
   assign is_head_c = i_pkt_valid && (word_c.flag == HEAD);
   assign is_body_c = i_pkt_valid && (word_c.flag == BODY);
   assign is_tail_c = i_pkt_valid && (word_c.flag == TAIL);

   // Per-PE readiness and byte filters; a broadcast dmac matches any enabled filter.
   for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
      logic dmac_hit, smac_hit, type_hit;
      assign ready_c[i] = i_usedw_dmaWR[i*USEDW_W +: USEDW_W] <= USEDW_W'(READY_THRESH);
      assign dmac_hit   = i_filter_dmac_en[i] && (i_pkt[DMAC_LSB +: 8] == i_filter_dmac[i*8 +: 8]);
      assign smac_hit   = i_filter_smac_en[i] && (i_pkt[SMAC_LSB +: 8] == i_filter_smac[i*8 +: 8]);
      assign type_hit   = i_filter_type_en[i] && (i_pkt[TYPE_LSB +: 8] == i_filter_type[i*8 +: 8]);
      assign hit_c[i]   = i_filter_en[i] &&
                          ((i_pkt[DMAC_LSB +: 8] == 8'hFF) || dmac_hit || smac_hit || type_hit);
   end

   assign claim_c     = i_pkt[BMAP_LSB +: NUM_PE] | hit_c;
   assign elig_c      = ready_c & i_start_en;
   assign fallback_c  = (RR_FALLBACK != 0) && i_rr_en && (claim_c == '0);
   assign head_bmap_c = fallback_c ? rr_grant_c : (claim_c & elig_c);
   assign rr_adv_c    = is_head_c && fallback_c && (rr_grant_c != '0);

   if (RR_FALLBACK != 0) begin : g_rr
      dispatch_rr_pick #(.NUM_PE(NUM_PE)) u_rr (
         .clk_i   (i_clk),
         .rst_i   (i_rst),
         .req_i   (elig_c),
         .adv_i   (rr_adv_c),
         .grant_o (rr_grant_c)
      );
   end else begin : g_no_rr
      assign rr_grant_c = '0;
   end

   // A head is always accepted, even mid-packet; that case abandons the old packet.
   always_comb begin
      state_d   = state_q;
      bmap_d    = bmap_q;
      len_d     = len_q;
      valid_d   = '0;
      wren_d    = '0;
      din_len_d = din_len_q;
      drop_d    = drop_q;
      err_d     = err_q;

      if (is_head_c) begin
         if (state_q == ST_BODY) err_d = err_q + CNT_W'(1);
         if (head_bmap_c == '0) drop_d = drop_q + CNT_W'(1);
         bmap_d  = head_bmap_c;
         valid_d = head_bmap_c;
         len_d   = LEN_W'(16);
         state_d = ST_BODY;
      end else if (state_q == ST_BODY) begin
         if (is_body_c) begin
            valid_d = bmap_q;
            len_d   = len_add(len_q, 5'd16);
         end else if (is_tail_c) begin
            valid_d   = bmap_q;
            len_d     = len_add(len_q, tail_bytes(i_pkt[VBYTES_LSB +: 4]));
            din_len_d = len_d;
            wren_d    = bmap_q;
            state_d   = ST_IDLE;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         bmap_q    <= '0;
         len_q     <= '0;
         valid_q   <= '0;
         wren_q    <= '0;
         din_len_q <= '0;
         drop_q    <= '0;
         err_q     <= '0;
         pkt_q     <= '0;
      end else begin
         state_q   <= state_d;
         bmap_q    <= bmap_d;
         len_q     <= len_d;
         valid_q   <= valid_d;
         wren_q    <= wren_d;
         din_len_q <= din_len_d;
         drop_q    <= drop_d;
         err_q     <= err_d;
         pkt_q     <= i_pkt;
      end
   end

   assign o_pkt         = pkt_q;
   assign o_pkt_valid   = valid_q;
   assign o_wren_length = wren_q;
   assign o_din_length  = din_len_q;
   assign o_drop_cnt    = drop_q;
   assign o_err_cnt     = err_q;
   assign d_state_1b    = state_q;

endmodule

// File: tb/tb_pkt_dispatch_mc.sv
// Directed and randomized bench for pkt_dispatch_mc with a packet-level reference model.
module tb_pkt_dispatch_mc;

   logic         clk, i_rst, i_pkt_valid, i_rr_en, d_state_1b;
   logic [133:0] i_pkt, o_pkt;
   logic [2:0]   o_pkt_valid, o_wren_length;
   logic [2:0]   i_filter_en, i_filter_dmac_en, i_filter_smac_en, i_filter_type_en, i_start_en;
   logic [29:0]  i_usedw_dmaWR;
   logic [23:0]  i_filter_dmac, i_filter_smac, i_filter_type;
   logic [15:0]  o_din_length;
   logic [31:0]  o_drop_cnt, o_err_cnt;

   int checks = 0;
   int errors = 0;

   bit         m_in;
   logic [2:0] m_bmap;
   int         m_len, m_ptr, m_drop, m_err;

   logic [2:0]  last_valid, last_wren, head_v;
   logic [15:0] last_len;
   logic [2:0]  hv [4];

   pkt_dispatch_mc dut (
      .i_clk(clk), .i_rst(i_rst), .i_pkt_valid(i_pkt_valid), .i_pkt(i_pkt),
      .o_pkt_valid(o_pkt_valid), .o_pkt(o_pkt), .i_usedw_dmaWR(i_usedw_dmaWR),
      .o_din_length(o_din_length), .o_wren_length(o_wren_length),
      .i_filter_en(i_filter_en), .i_filter_dmac_en(i_filter_dmac_en),
      .i_filter_smac_en(i_filter_smac_en), .i_filter_type_en(i_filter_type_en),
      .i_filter_dmac(i_filter_dmac), .i_filter_smac(i_filter_smac), .i_filter_type(i_filter_type),
      .i_start_en(i_start_en), .i_rr_en(i_rr_en),
      .o_drop_cnt(o_drop_cnt), .o_err_cnt(o_err_cnt), .d_state_1b(d_state_1b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [133:0] got, input logic [133:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [133:0] mk(input logic [1:0] f, input logic [3:0] nib, input logic [2:0] bm,
                                       input logic [7:0] d, input logic [7:0] s, input logic [7:0] t);
      logic [133:0] w;
      w[31:0]     = $urandom;
      w[63:32]    = $urandom;
      w[95:64]    = $urandom;
      w[127:96]   = $urandom;
      w[133:128]  = 6'($urandom);
      w[133:132]  = f;
      w[131:128]  = nib;
      w[82:80]    = bm;
      w[127:120]  = d;
      w[119:112]  = s;
      w[111:104]  = t;
      return w;
   endfunction

   function automatic logic [7:0] pick();
      case ($urandom_range(0, 3))
         0:       return 8'h12;
         1:       return 8'h34;
         2:       return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   // Head decision from the rules: claimants that are ready and started, else the next eligible PE in rotation.
   task automatic model_bitmap(input logic [133:0] w, output logic [2:0] bm);
      bit         ok [3];
      logic [2:0] claim;
      bit         hit;
      claim = '0;
      for (int i = 0; i < 3; i++) begin
         ok[i] = (i_usedw_dmaWR[i*10 +: 10] <= 10'd28) && i_start_en[i];
         hit = i_filter_en[i] && ((w[127:120] == 8'hFF) ||
               (i_filter_dmac_en[i] && w[127:120] == i_filter_dmac[i*8 +: 8]) ||
               (i_filter_smac_en[i] && w[119:112] == i_filter_smac[i*8 +: 8]) ||
               (i_filter_type_en[i] && w[111:104] == i_filter_type[i*8 +: 8]));
         claim[i] = w[80+i] | hit;
      end
      bm = '0;
      if (claim == 3'b000 && i_rr_en) begin
         for (int k = 0; k < 3; k++) begin
            int j;
            j = (m_ptr + k) % 3;
            if (ok[j]) begin
               bm[j] = 1'b1;
               m_ptr = (j + 1) % 3;
               break;
            end
         end
      end else begin
         for (int i = 0; i < 3; i++) bm[i] = claim[i] && ok[i];
      end
   endtask

   task automatic model(input logic v, input logic [133:0] w, output logic [2:0] ev,
                        output logic [2:0] ewr, output logic [15:0] elen);
      int add;
      ev = '0; ewr = '0; elen = '0;
      if (!v) return;
      case (w[133:132])
         2'b11: begin
            if (m_in) m_err++;
            model_bitmap(w, m_bmap);
            if (m_bmap == 3'b000) m_drop++;
            ev = m_bmap; m_len = 16; m_in = 1'b1;
         end
         2'b01: if (m_in) begin
            ev = m_bmap;
            m_len = (m_len + 16 > 65535) ? 65535 : m_len + 16;
         end
         2'b10: if (m_in) begin
            add = (w[131:128] == 4'd0) ? 16 : int'(w[131:128]);
            ev = m_bmap;
            m_len = (m_len + add > 65535) ? 65535 : m_len + add;
            ewr = m_bmap; elen = 16'(m_len); m_in = 1'b0;
         end
         default: ;
      endcase
   endtask

   task automatic step(input logic v, input logic [133:0] w);
      logic [2:0]  ev, ewr;
      logic [15:0] elen;
      i_pkt_valid = v;
      i_pkt       = w;
      model(v, w, ev, ewr, elen);
      @(posedge clk);
      #1;
      chk("pkt_echo", o_pkt, w);
      chk("pkt_valid", o_pkt_valid, ev);
      chk("wren_length", o_wren_length, ewr);
      if (ewr != 3'b000) chk("din_length", o_din_length, elen);
      chk("drop_cnt", o_drop_cnt, m_drop);
      chk("err_cnt", o_err_cnt, m_err);
      last_valid = o_pkt_valid;
      if (o_wren_length != 3'b000) begin
         last_wren = o_wren_length;
         last_len  = o_din_length;
      end
   endtask

   task automatic send_pkt(input logic [2:0] bm, input logic [7:0] d, input logic [7:0] s, input logic [7:0] t,
                           input int nbody, input logic [3:0] nib, input bit tail, input bit gaps);
      step(1'b1, mk(2'b11, 4'($urandom), bm, d, s, t));
      head_v = last_valid;
      for (int b = 0; b < nbody; b++) begin
         if (gaps && $urandom_range(0, 2) == 0) step(1'b0, mk(2'($urandom), 4'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)));
         step(1'b1, mk(2'b01, 4'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)));
      end
      if (tail) begin
         if (gaps && $urandom_range(0, 2) == 0) step(1'b0, mk(2'($urandom), 4'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)));
         step(1'b1, mk(2'b10, nib, 3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)));
      end
   endtask

   task automatic do_reset();
      i_pkt_valid = 1'b0;
      i_rst = 1'b1;
      #1;
      chk("rst_pkt", o_pkt, '0);
      chk("rst_valid", o_pkt_valid, '0);
      chk("rst_wren", o_wren_length, '0);
      chk("rst_len", o_din_length, '0);
      chk("rst_drop", o_drop_cnt, '0);
      chk("rst_err", o_err_cnt, '0);
      chk("rst_state", d_state_1b, '0);
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      m_in = 1'b0; m_ptr = 0; m_drop = 0; m_err = 0; m_len = 0; m_bmap = '0;
   endtask

   initial begin
      i_rst = 1'b0; i_pkt_valid = 1'b0; i_pkt = '0;
      i_usedw_dmaWR = '0; i_start_en = 3'b111; i_rr_en = 1'b0;
      i_filter_en = '0; i_filter_dmac_en = '0; i_filter_smac_en = '0; i_filter_type_en = '0;
      i_filter_dmac = '0; i_filter_smac = '0; i_filter_type = '0;
      last_valid = '0; last_wren = '0; last_len = '0; head_v = '0;
      #2;
      do_reset();

      // Header bitmap only
      send_pkt(3'b101, 8'h00, 8'h00, 8'h00, 2, 4'd5, 1'b1, 1'b0);
      chk("t1_head_valid", head_v, 3'b101);
      chk("t1_len", last_len, 16'd53);
      chk("t1_wren", last_wren, 3'b101);

      // Filter match and broadcast
      i_filter_en = 3'b010; i_filter_dmac_en = 3'b010; i_filter_dmac = 24'h00_12_00;
      send_pkt(3'b000, 8'h12, 8'h00, 8'h00, 1, 4'd0, 1'b1, 1'b0);
      chk("t2_dmac_match", head_v, 3'b010);
      i_filter_en = 3'b111; i_filter_dmac_en = 3'b000;
      send_pkt(3'b000, 8'hFF, 8'h00, 8'h00, 0, 4'd1, 1'b1, 1'b0);
      chk("t2_broadcast", head_v, 3'b111);
      i_filter_en = 3'b000;

      // Not ready, then not started
      i_usedw_dmaWR[9:0] = 10'd29;
      last_wren = '0;
      send_pkt(3'b001, 8'h00, 8'h00, 8'h00, 1, 4'd2, 1'b1, 1'b0);
      chk("t3_notready_drop", o_drop_cnt, 32'd1);
      chk("t3_notready_wren", last_wren, 3'b000);
      i_usedw_dmaWR[9:0] = 10'd0; i_start_en = 3'b110;
      send_pkt(3'b001, 8'h00, 8'h00, 8'h00, 1, 4'd2, 1'b1, 1'b0);
      chk("t3_nostart_drop", o_drop_cnt, 32'd2);
      i_start_en = 3'b111;

      // Round-robin fallback
      i_rr_en = 1'b1;
      for (int p = 0; p < 4; p++) begin
         send_pkt(3'b000, 8'h00, 8'h00, 8'h00, 0, 4'd4, 1'b1, 1'b0);
         hv[p] = head_v;
      end
      chk("t4_rr0", hv[0], 3'b001); chk("t4_rr1", hv[1], 3'b010);
      chk("t4_rr2", hv[2], 3'b100); chk("t4_rr3", hv[3], 3'b001);
      do_reset();
      i_usedw_dmaWR[19:10] = 10'd29;
      for (int p = 0; p < 4; p++) begin
         send_pkt(3'b000, 8'h00, 8'h00, 8'h00, 0, 4'd4, 1'b1, 1'b0);
         hv[p] = head_v;
      end
      chk("t4_skip0", hv[0], 3'b001); chk("t4_skip1", hv[1], 3'b100);
      chk("t4_skip2", hv[2], 3'b001); chk("t4_skip3", hv[3], 3'b100);
      i_usedw_dmaWR[19:10] = 10'd0; i_rr_en = 1'b0;

      // Truncation, then back-to-back tail->head
      last_wren = '0;
      send_pkt(3'b011, 8'h00, 8'h00, 8'h00, 2, 4'd0, 1'b0, 1'b0);
      send_pkt(3'b110, 8'h00, 8'h00, 8'h00, 1, 4'd0, 1'b1, 1'b0);
      chk("t5_err", o_err_cnt, 32'd1);
      chk("t5_len", last_len, 16'd48);
      chk("t5_wren", last_wren, 3'b110);
      send_pkt(3'b001, 8'h00, 8'h00, 8'h00, 0, 4'd3, 1'b1, 1'b0);
      chk("t5_b2b_len_a", last_len, 16'd19);
      send_pkt(3'b010, 8'h00, 8'h00, 8'h00, 0, 4'd7, 1'b1, 1'b0);
      chk("t5_b2b_head", head_v, 3'b010);
      chk("t5_b2b_len_b", last_len, 16'd23);

      // Length saturation
      send_pkt(3'b001, 8'h00, 8'h00, 8'h00, 4094, 4'd0, 1'b1, 1'b0);
      chk("sat_len", last_len, 16'hFFFF);

      // Reset mid-packet
      send_pkt(3'b111, 8'h00, 8'h00, 8'h00, 1, 4'd0, 1'b0, 1'b0);
      do_reset();
      send_pkt(3'b100, 8'h00, 8'h00, 8'h00, 0, 4'd0, 1'b1, 1'b0);
      chk("t6_len", last_len, 16'd32);
      chk("t6_wren", last_wren, 3'b100);

      // Randomized traffic against the model
      for (int p = 0; p < 80; p++) begin
         for (int i = 0; i < 3; i++) i_usedw_dmaWR[i*10 +: 10] = 10'($urandom_range(24, 33));
         i_start_en       = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
         i_filter_en      = 3'($urandom);
         i_filter_dmac_en = 3'($urandom);
         i_filter_smac_en = 3'($urandom);
         i_filter_type_en = 3'($urandom);
         i_filter_dmac    = {pick(), pick(), pick()};
         i_filter_smac    = {pick(), pick(), pick()};
         i_filter_type    = {pick(), pick(), pick()};
         i_rr_en          = 1'($urandom);
         if (!m_in && $urandom_range(0, 4) == 0)
            step(1'b1, mk(2'b10, 4'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)));
         send_pkt(($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom), pick(), pick(), pick(),
                  $urandom_range(0, 3), 4'($urandom), $urandom_range(0, 5) != 0, 1'b1);
      end
      step(1'b0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
